// File: rtl/score_pkg.sv
// Shared types, constants and helpers for the BCD score tracker.
package score_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ADD    = 2'd1;
  localparam state_t ST_COMMIT = 2'd2;
  localparam state_t ST_CLEAR  = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] BCD_MAX   = 4'd9;

  // Active-low {g,f,e,d,c,b,a}; codes 10..15 show A..F so bad digits are visible.
  function automatic logic [6:0] seg_lut(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  function automatic logic [3:0] clamp_bcd(input logic [3:0] value);
    return (value > BCD_MAX) ? BCD_MAX : value;
  endfunction

endpackage

// File: rtl/score_tracker_seg.sv
// One BCD digit to active-low 7-segment pattern, with a blanking override.
module bcd_seg_decoder
  import score_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_c_o
);

  assign seg_c_o = blank_i ? SEG_BLANK : seg_lut(digit_i);

endmodule

// File: rtl/score_tracker.sv
// BCD score / high-score keeper: award FIFO, digit-serial BCD adder,
// commit-on-collision and 7-segment drive for both values.
module score_tracker
  import score_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BLANK_LZ   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    apple_eaten,
  input  logic [3:0]              add_pts,
  input  logic                    collision,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [4*NUM_DIGITS-1:0] high_bcd,
  output logic                    new_record,
  output logic                    saturated,
  output logic                    overflow,
  output logic                    busy,
  output logic [7*NUM_DIGITS-1:0] seg_score,
  output logic [7*NUM_DIGITS-1:0] seg_high
);

  localparam int unsigned SW   = 4 * NUM_DIGITS;
  localparam int unsigned PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PTRW = PW + 1;
  localparam int unsigned IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_t          state_q, state_d;
  logic [SW-1:0]   score_q, score_d;
  logic [SW-1:0]   high_q, high_d;
  logic            new_record_q, new_record_d;
  logic            saturated_q, saturated_d;
  logic            overflow_q, overflow_d;
  logic            commit_req_q, commit_req_d;
  logic            busy_q, busy_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [3:0]      carry_q, carry_d;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]      fifo_mem_q [FIFO_DEPTH];

  logic            fifo_empty_c, fifo_full_c, push_c, drop_c;
  logic [3:0]      pop_data_c, cur_digit_c, new_digit_c;
  logic [4:0]      sum_c;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign fifo_empty_c = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_c  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign push_c       = apple_eaten && !commit_req_q && !fifo_full_c;
  assign drop_c       = apple_eaten && !commit_req_q && fifo_full_c;
  assign pop_data_c   = fifo_mem_q[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
    end else if (push_c) begin
      fifo_mem_q[wr_ptr_q[PW-1:0]] <= clamp_bcd(add_pts);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      score_q      <= '0;
      high_q       <= '0;
      new_record_q <= 1'b0;
      saturated_q  <= 1'b0;
      overflow_q   <= 1'b0;
      commit_req_q <= 1'b0;
      busy_q       <= 1'b0;
      idx_q        <= '0;
      carry_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      high_q       <= high_d;
      new_record_q <= new_record_d;
      saturated_q  <= saturated_d;
      overflow_q   <= overflow_d;
      commit_req_q <= commit_req_d;
      busy_q       <= busy_d;
      idx_q        <= idx_d;
      carry_q      <= carry_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    high_d       = high_q;
    new_record_d = new_record_q;
    saturated_d  = saturated_q;
    overflow_d   = overflow_q | drop_c;
    commit_req_d = commit_req_q | collision;
    idx_d        = idx_q;
    carry_d      = carry_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q + PTRW'(push_c);
    cur_digit_c  = '0;
    new_digit_c  = '0;

    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) cur_digit_c = score_q[4*i +: 4];
    end
    sum_c = {1'b0, cur_digit_c} + {1'b0, carry_q};

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_c) begin
          rd_ptr_d = rd_ptr_q + PTRW'(1);
          carry_d  = pop_data_c;
          idx_d    = '0;
          state_d  = ST_ADD;
        end else if (commit_req_q) begin
          state_d = ST_COMMIT;
        end
      end
      ST_ADD: begin
        // A pinned score swallows the award in one cycle.
        if (saturated_q) begin
          state_d = ST_IDLE;
        end else begin
          new_digit_c = (sum_c >= 5'd10) ? 4'(sum_c - 5'd10) : sum_c[3:0];
          for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) score_d[4*i +: 4] = new_digit_c;
          end
          if (sum_c < 5'd10) begin
            state_d = ST_IDLE;
          end else if (idx_q == IW'(NUM_DIGITS - 1)) begin
            score_d     = {NUM_DIGITS{BCD_MAX}};
            saturated_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            idx_d   = idx_q + IW'(1);
            carry_d = 4'd1;
          end
        end
      end
      ST_COMMIT: begin
        if (score_q > high_q) begin
          high_d       = score_q;
          new_record_d = 1'b1;
        end
        state_d = ST_CLEAR;
      end
      default: begin
        score_d      = '0;
        saturated_d  = 1'b0;
        commit_req_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase

    if (push_c) new_record_d = 1'b0;

    busy_d = (state_d != ST_IDLE) || (wr_ptr_d != rd_ptr_d) || commit_req_d;
  end

  // Leading-zero blanking scans from the top digit down; digit 0 never blanks.
  logic [NUM_DIGITS-1:0] score_blank_c, high_blank_c;
  logic                  score_zero_c, high_zero_c;

  always_comb begin
    score_blank_c = '0;
    high_blank_c  = '0;
    score_zero_c  = 1'b1;
    high_zero_c   = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      score_zero_c = score_zero_c && (score_q[4*i +: 4] == 4'd0);
      high_zero_c  = high_zero_c && (high_q[4*i +: 4] == 4'd0);
      if ((BLANK_LZ != 0) && (i != 0)) begin
        score_blank_c[i] = score_zero_c;
        high_blank_c[i]  = high_zero_c;
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
    bcd_seg_decoder u_score_dec (
      .digit_i (score_q[4*g +: 4]),
      .blank_i (score_blank_c[g]),
      .seg_c_o (seg_score[7*g +: 7])
    );
    bcd_seg_decoder u_high_dec (
      .digit_i (high_q[4*g +: 4]),
      .blank_i (high_blank_c[g]),
      .seg_c_o (seg_high[7*g +: 7])
    );
  end

  assign score_bcd  = score_q;
  assign high_bcd   = high_q;
  assign new_record = new_record_q;
  assign saturated  = saturated_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;

endmodule
